// File: rtl/mem_port_arbiter_pkg.sv
// Types shared by the unified instruction/data RAM arbiter and its users.
package cpu_mem_pkg;

   localparam int DEF_AW = 16;
   localparam int DEF_DW = 16;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_IF,
      GRANT_DM
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_IF,
      GNT_DM
   } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, RAM and stall signals around the single-ported RAM arbiter.
interface mem_port_arbiter_if
   import cpu_mem_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;

   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ack;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          stall_if;
   logic          stall_mem;

   // arbiter side
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_ack, dm_rdata, dm_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_mem
   );

   // pipeline stages plus RAM model side
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_ack, dm_rdata, dm_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_mem
   );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Grant decision between fetch and load/store, with a bounded DM burst so IF cannot starve.
module mem_arb_pick
   import cpu_mem_pkg::*;
#(
   parameter int MAX_DM_BURST = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   if_req,
   input  logic   dm_req,
   input  logic   decide,
   output grant_t grant
);

   localparam int BW = $clog2(MAX_DM_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DM_BURST);

   if (MAX_DM_BURST < 1) begin : g_burst_chk
      $error("MAX_DM_BURST must be at least 1");
   end

   logic [BW-1:0] burst;

   always_comb begin
      grant = GNT_NONE;
      if (decide) begin
         if (dm_req && (!if_req || (burst < BURST_MAX))) begin
            grant = GNT_DM;
         end else if (if_req) begin
            grant = GNT_IF;
         end
      end
   end

   // burst only counts DM wins that made IF wait
   always_ff @(posedge clk) begin
      if (reset) begin
         burst <= '0;
      end else begin
         case (grant)
            GNT_IF: burst <= '0;
            GNT_DM: begin
               if (!if_req) begin
                  burst <= '0;
               end else if (burst != BURST_MAX) begin
                  burst <= burst + BW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified RAM between IF and DM: one fixed-latency access at a time, one-cycle ack.
//
// state    | meaning
// IDLE     | waiting for a request; no acceptance while an ack is being presented
// GRANT_IF | fetch access in flight, cnt counts down the RAM latency
// GRANT_DM | load/store access in flight, cnt counts down the RAM latency
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int DW           = DEF_DW,
   parameter int LAT          = 2,
   parameter int MAX_DM_BURST = 4
) (
   input  logic clk,
   input  logic reset,
   mem_port_arbiter_if.slave bus
);

   if (LAT < 1 || LAT > 15) begin : g_lat_chk
      $error("LAT must be within 1..15");
   end
   if (AW < 1 || DW < 1) begin : g_width_chk
      $error("AW and DW must be positive");
   end

   localparam logic [3:0] LAT_C = 4'(LAT);

   arb_state_t state;
   logic [3:0] cnt;
   logic       decide;
   grant_t     grant;

   assign decide = (state == IDLE) && !bus.if_ack && !bus.dm_ack;

   mem_arb_pick #(
      .MAX_DM_BURST(MAX_DM_BURST)
   ) u_pick (
      .clk    (clk),
      .reset  (reset),
      .if_req (bus.if_req),
      .dm_req (bus.dm_req),
      .decide (decide),
      .grant  (grant)
   );

   assign bus.stall_if  = bus.if_req & ~bus.if_ack;
   assign bus.stall_mem = bus.dm_req & ~bus.dm_ack;

   // mem_rdata is sampled on the edge that raises the ack, LAT cycles into the grant
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.if_ack    <= 1'b0;
         bus.dm_ack    <= 1'b0;
         bus.if_rdata  <= '0;
         bus.dm_rdata  <= '0;
      end else begin
         bus.if_ack <= 1'b0;
         bus.dm_ack <= 1'b0;
         bus.mem_en <= 1'b0;
         bus.mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (grant == GNT_IF) begin
                  state         <= GRANT_IF;
                  cnt           <= LAT_C;
                  bus.mem_en    <= 1'b1;
                  bus.mem_addr  <= bus.if_addr;
                  bus.mem_wdata <= '0;
               end else if (grant == GNT_DM) begin
                  state         <= GRANT_DM;
                  cnt           <= LAT_C;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= bus.dm_we;
                  bus.mem_addr  <= bus.dm_addr;
                  bus.mem_wdata <= bus.dm_wdata;
               end
            end
            GRANT_IF, GRANT_DM: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= IDLE;
                  if (state == GRANT_IF) begin
                     bus.if_ack   <= 1'b1;
                     bus.if_rdata <= bus.mem_rdata;
                  end else begin
                     bus.dm_ack   <= 1'b1;
                     bus.dm_rdata <= bus.mem_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized IF/DM traffic against a cycle-schedule model and a read-data scoreboard.
module tb_mem_port_arbiter;

   localparam int LAT       = 2;
   localparam int MAX_BURST = 4;

   typedef struct packed {
      logic        st;
      logic [15:0] d;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   logic ram_load;
   logic model_on;

   int vec = 0;
   int mis = 0;

   logic [15:0] ram      [256];
   logic [15:0] ram_init [256];
   logic [15:0] shadow   [256];
   int          en_age;

   logic [15:0] if_q [$];
   sb_t         dm_q [$];

   // model state
   int          m_cyc, m_g, m_who, m_burst;
   logic [15:0] m_addr, m_wd;
   logic        m_we;
   logic        e_en, e_ia, e_da, in_win;

   mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

   mem_port_arbiter #(
      .AW(16), .DW(16), .LAT(LAT), .MAX_DM_BURST(MAX_BURST)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // RAM: data valid from the LAT-th cycle of the grant, junk before that
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 256; i++) ram[i] <= ram_init[i];
         en_age <= 0;
      end else if (bus.mem_en) begin
         en_age <= 1;
         if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      end else if (en_age != 0 && en_age < 1000) begin
         en_age <= en_age + 1;
      end
   end

   assign bus.mem_rdata = (bus.mem_en ? (LAT == 1) : (en_age > 0 && en_age >= LAT - 1))
                          ? ram[bus.mem_addr[7:0]] : 16'hDEAD;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_if(input logic [15:0] a);
      int n;
      bus.if_req  = 1'b1;
      bus.if_addr = a;
      if_q.push_back(ram_init[a[7:0]]);
      n = 0;
      do begin @(negedge clk); n++; end while (bus.if_ack !== 1'b1 && n < 60);
      check("if_ack_timeout", bus.if_ack, 1);
      @(posedge clk); #1;
      bus.if_req = 1'b0;
   endtask

   task automatic do_dm(input logic we, input logic [15:0] a, input logic [15:0] d);
      int  n;
      sb_t e;
      bus.dm_req   = 1'b1;
      bus.dm_we    = we;
      bus.dm_addr  = a;
      bus.dm_wdata = d;
      e.st = we;
      e.d  = we ? 16'h0000 : shadow[a[7:0]];
      if (we) shadow[a[7:0]] = d;
      dm_q.push_back(e);
      n = 0;
      do begin @(negedge clk); n++; end while (bus.dm_ack !== 1'b1 && n < 60);
      check("dm_ack_timeout", bus.dm_ack, 1);
      @(posedge clk); #1;
      bus.dm_req = 1'b0;
   endtask

   task automatic if_stream(input int cnt);
      int gap;
      for (int k = 0; k < cnt; k++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin @(posedge clk); #1; end
         do_if({8'($urandom), 1'b0, 7'($urandom)});
      end
   endtask

   task automatic dm_stream(input int cnt);
      int          gap;
      logic        we;
      logic [15:0] a;
      for (int k = 0; k < cnt; k++) begin
         gap = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4);
         repeat (gap) begin @(posedge clk); #1; end
         we = 1'($urandom_range(0, 1));
         a  = we ? {8'($urandom), 1'b1, 7'($urandom)} : {8'($urandom), 8'($urandom)};
         do_dm(we, a, 16'($urandom));
      end
   endtask

   // Cycle schedule from the arbitration rules: accept at t, mem_en at t+1, ack at t+1+LAT.
   initial begin
      m_cyc = 0; m_g = -100; m_who = 0; m_burst = 0;
      m_addr = '0; m_wd = '0; m_we = 1'b0;
      wait (model_on === 1'b1);
      forever begin
         @(negedge clk);
         e_en   = (m_cyc == m_g);
         in_win = (m_cyc >= m_g) && (m_cyc <= m_g + LAT);
         e_ia   = (m_who == 0) && (m_cyc == m_g + LAT);
         e_da   = (m_who == 1) && (m_cyc == m_g + LAT);
         check("mem_en", bus.mem_en, e_en);
         check("mem_we", bus.mem_we, e_en & m_we);
         check("if_ack", bus.if_ack, e_ia);
         check("dm_ack", bus.dm_ack, e_da);
         check("stall_if", bus.stall_if, bus.if_req & ~e_ia);
         check("stall_mem", bus.stall_mem, bus.dm_req & ~e_da);
         if (in_win) begin
            check("mem_addr", bus.mem_addr, m_addr);
            if (m_we) check("mem_wdata", bus.mem_wdata, m_wd);
         end
         if (reset) begin
            m_g = -100;
            m_burst = 0;
         end else if (m_cyc > m_g + LAT && (bus.if_req || bus.dm_req)) begin
            if (bus.dm_req && (!bus.if_req || m_burst < MAX_BURST)) begin
               m_who = 1; m_addr = bus.dm_addr; m_we = bus.dm_we; m_wd = bus.dm_wdata;
               m_burst = bus.if_req ? ((m_burst < MAX_BURST) ? m_burst + 1 : MAX_BURST) : 0;
            end else begin
               m_who = 0; m_addr = bus.if_addr; m_we = 1'b0; m_wd = '0;
               m_burst = 0;
            end
            m_g = m_cyc + 1;
         end
         m_cyc++;
      end
   end

   // Scoreboard monitor: pops an expectation on every ack.
   initial begin
      logic [15:0] exp_if;
      sb_t         exp_dm;
      forever begin
         @(negedge clk);
         if (bus.if_ack === 1'b1) begin
            if (if_q.size() == 0) check("if_ack_unexpected", 1, 0);
            else begin
               exp_if = if_q.pop_front();
               check("if_rdata", bus.if_rdata, exp_if);
            end
         end
         if (bus.dm_ack === 1'b1) begin
            if (dm_q.size() == 0) check("dm_ack_unexpected", 1, 0);
            else begin
               exp_dm = dm_q.pop_front();
               if (!exp_dm.st) check("dm_rdata", bus.dm_rdata, exp_dm.d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      logic saw_ack;
      reset = 1'b1; ram_load = 1'b1; model_on = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         ram_init[i] = 16'($urandom);
         shadow[i]   = ram_init[i];
      end
      ram_init[8'h10] = 16'hA5A5;
      shadow[8'h10]   = 16'hA5A5;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_if_ack", bus.if_ack, 0);
      check("rst_dm_ack", bus.dm_ack, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_if_rdata", bus.if_rdata, 0);
      check("rst_dm_rdata", bus.dm_rdata, 0);
      check("rst_stall_if", bus.stall_if, 0);
      check("rst_stall_mem", bus.stall_mem, 0);

      @(posedge clk); #1;
      reset = 1'b0; ram_load = 1'b0; model_on = 1'b1;

      do_if(16'h0010);
      do_dm(1'b1, 16'h0380, 16'h1234);
      do_dm(1'b0, 16'h0380, 16'h0000);

      fork
         if_stream(50);
         dm_stream(70);
      join

      // reset one cycle after mem_en of a DM load: access dropped, no ack
      repeat (6) @(posedge clk);
      #1;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0090;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.mem_en !== 1'b1 && n < 10);
      check("rst_test_mem_en", bus.mem_en, 1);
      @(posedge clk); #1;
      reset = 1'b1; bus.dm_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_mem_addr", bus.mem_addr, 0);
      check("midrst_if_rdata", bus.if_rdata, 0);
      check("midrst_dm_rdata", bus.dm_rdata, 0);
      saw_ack = 1'b0;
      repeat (LAT + 3) begin
         @(negedge clk);
         if (bus.dm_ack !== 1'b0) saw_ack = 1'b1;
      end
      check("midrst_no_dm_ack", saw_ack, 0);
      @(posedge clk); #1;
      do_if(16'h0042);

      repeat (4) @(posedge clk);
      check("if_q_drained", if_q.size(), 0);
      check("dm_q_drained", dm_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
